// File: rtl/conv_output_collector.sv
// conv_output_collector: receives the convolution core's result stream,
// buffers each result in a small FIFO together with its linear output-memory
// address, and writes it out over a valid/ready port. A layer is finished
// once every expected output has been either written or dropped.
//
// Handshake: a write transfers on any cycle where wr_valid && wr_ready.
// While wr_valid is high and wr_ready is low, wr_valid/wr_data/wr_addr hold.
// The input side has no ready: a result that cannot be buffered is dropped
// and flagged in the sticky overflow bit.
//
// Optional build macro CONV_OUTPUT_COLLECTOR_RELU_EN: when defined, negative
// results are clamped to zero before buffering. Undefined, data passes as-is.
module conv_output_collector #(
  parameter  int DATA_WIDTH         = 16,
  parameter  int FEATURE_MAP_WIDTH  = 128,
  parameter  int FEATURE_MAP_HEIGHT = 128,
  parameter  int OUTPUT_NB_CHANNELS = 64,
  parameter  int FIFO_DEPTH         = 4,
  localparam int TOTAL  = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int ADDR_W = $clog2(TOTAL),
  localparam int XW     = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW     = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CW     = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic [XW-1:0]                in_x,
  input  logic [YW-1:0]                in_y,
  input  logic [CW-1:0]                in_ch,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [ADDR_W:0]              count,
  output logic [1:0]                   dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + ADDR_W;

  localparam logic [XW:0]     X_LIM   = (XW+1)'(FEATURE_MAP_WIDTH);
  localparam logic [YW:0]     Y_LIM   = (YW+1)'(FEATURE_MAP_HEIGHT);
  localparam logic [CW:0]     C_LIM   = (CW+1)'(OUTPUT_NB_CHANNELS);
  localparam logic [PW:0]     OCC_MAX = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W+1:0] SUM_TOTAL = (ADDR_W+2)'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [ADDR_W:0]       r_count;
  logic [ADDR_W:0]       r_drops;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_occ;

  logic                  w_in_range;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_collect;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [ADDR_W:0]       w_count_nxt;
  logic [ADDR_W:0]       w_drops_nxt;
  logic [PW:0]           w_occ_nxt;
  logic [ADDR_W+1:0]     w_sum_nxt;
  logic                  w_finish;

  // Tag range check and linear address (channel-major, then row, then column)
  assign w_in_range = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM) &&
                      ({1'b0, in_ch} < C_LIM);
  assign w_addr = ADDR_W'(in_ch) * ADDR_W'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT)
                + ADDR_W'(in_y) * ADDR_W'(FEATURE_MAP_WIDTH)
                + ADDR_W'(in_x);

`ifdef CONV_OUTPUT_COLLECTOR_RELU_EN
  assign w_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign w_data = in_data;
`endif

  // A push is allowed into a full FIFO only when the head leaves in the same cycle
  assign w_empty   = (r_occ == '0);
  assign w_full    = (r_occ == OCC_MAX);
  assign w_collect = (r_state == S_COLLECT);
  assign w_pop     = !w_empty && wr_ready;
  assign w_push    = w_collect && in_valid && w_in_range && (!w_full || w_pop);
  assign w_drop    = w_collect && in_valid && !w_push;

  // Completion looks at next-cycle totals so the final pop can finish the layer
  assign w_count_nxt = r_count + (ADDR_W+1)'(w_pop);
  assign w_drops_nxt = r_drops + (ADDR_W+1)'(w_drop);
  assign w_occ_nxt   = r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_sum_nxt   = {1'b0, w_count_nxt} + {1'b0, w_drops_nxt};
  assign w_finish    = (w_sum_nxt == SUM_TOTAL) && (w_occ_nxt == '0);

  // Layer control FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_COLLECT;
            r_busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Per-layer write count, drop count and sticky overflow
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_count    <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_count    <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_drops <= w_drops_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Result FIFO: entries are {address, data}; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_addr, w_data};
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_occ <= w_occ_nxt;
    end
  end

  assign wr_valid  = !w_empty;
  assign wr_addr   = r_mem[r_rptr][EW-1:DATA_WIDTH];
  assign wr_data   = r_mem[r_rptr][DATA_WIDTH-1:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: doc/conv_output_collector.md
Name: conv_output_collector

Overview:
- Downstream stage of the convolution core.
- Consumes the core's result stream: data, x, y and channel tags, valid only, no backpressure.
- Buffers each result in a small FIFO, computes its linear output-memory address, and writes it out over a valid/ready write port.
- Reports completion once every expected output has been accounted for.

Parameters:
DATA_WIDTH, 16, width of one signed output word
FEATURE_MAP_WIDTH, 128, number of x positions
FEATURE_MAP_HEIGHT, 128, number of y positions
OUTPUT_NB_CHANNELS, 64, number of output channels
FIFO_DEPTH, 4, result buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
arst_n  in  1  synchronous active-low reset
start  in  1  begin collection of one layer (pulse)
in_data  in  DATA_WIDTH  signed result from core
in_valid  in  1  result valid (no ready; core never stalls)
in_x  in  clog2(FEATURE_MAP_WIDTH)  result x coordinate
in_y  in  clog2(FEATURE_MAP_HEIGHT)  result y coordinate
in_ch  in  clog2(OUTPUT_NB_CHANNELS)  result channel
wr_data  out  DATA_WIDTH  word to output memory
wr_addr  out  ADDR_W = clog2(W*H*CH)  linear address
wr_valid  out  1  write request
wr_ready  in  1  memory accepts write
busy  out  1  high in COLLECT
done  out  1  one-cycle completion pulse
overflow  out  1  sticky: at least one result dropped
count  out  ADDR_W+1  results written this layer

Behaviour:
Reset and clocking:
- All state updates on posedge clk.
- arst_n sampled low: state IDLE, FIFO empty, all outputs 0, count 0, overflow 0.
- Reset mid-layer discards buffered entries.

State machine, IDLE -> COLLECT -> DONE -> IDLE:
- IDLE: start=1 moves to COLLECT next cycle; clears count, overflow and the internal drop counter.
  - in_valid is ignored in IDLE.
- COLLECT: busy=1. A start pulse here is ignored.
- DONE: lasts one cycle with done=1, busy=0. Returns to IDLE.

Address and optional transform:
- Address = in_ch*W*H + in_y*W + in_x, computed at push time, unsigned.
- Stored with the data; FIFO entry width = DATA_WIDTH + ADDR_W.

Push and drop rules:
- Push when in_valid in COLLECT and the FIFO is not full, or when it is full but a pop occurs the same cycle.
- Otherwise the result is dropped: overflow <= 1 (sticky) and the drop counter increments.
- Out-of-range tags (in_x>=W, in_y>=H or in_ch>=CH) are also dropped with the same effect, never written.

Write port:
- wr_valid = FIFO not empty; wr_data/wr_addr = head entry.
- Pop when wr_valid && wr_ready; count increments on each pop.
- wr_valid/wr_data/wr_addr hold stable while wr_valid && !wr_ready.
- Latency: push in cycle N gives wr_valid at cycle N+1 when FIFO was empty.
- Simultaneous push and pop keeps occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Completion:
- COLLECT -> DONE when count + drops == W*H*CH and the FIFO is empty, including after the final pop in the same cycle.
- done follows the last write by exactly 1 cycle.
- Writes still pending in DONE cannot exist. In IDLE the FIFO is always empty.

Optional Feature:
CONV_OUTPUT_COLLECTOR_RELU_EN
- Defined: negative in_data is replaced by 0 before being pushed; addressing and counting are unchanged.
- Undefined: in_data is stored unmodified, including sign.

Test Plan:
All scenarios use W=4, H=2, CH=2, DEPTH=4, total 16.
- Reset then start, 16 results in order with wr_ready=1 -> 16 writes, addresses 0..15, wr_valid 1 cycle after each in_valid, done pulse 1 cycle after the 16th write, count=16, overflow=0.
- Result x=3, y=1, ch=1, data=-5 -> wr_addr=15; wr_data=-5, or 0 with RELU_EN.
- wr_ready=0 held for 6 cycles during 6 back-to-back inputs -> first 4 buffered, 2 dropped, overflow=1; after release 4 writes; layer still completes with count=14.
- FIFO full with in_valid and wr_ready both high -> no drop, occupancy stays 4.
- in_valid in IDLE, and start pulsed during COLLECT -> both ignored, no write, no state change.
- arst_n low mid-layer with 3 entries buffered -> next cycle wr_valid=0, busy=0, count=0, state IDLE.
